// File: rtl/adder_pkg.sv
// Shared constants for the ripple-carry adder block.
// Holds the default operand width used by the top-level parameter.
package adder_pkg;

    localparam int ADDER_WIDTH = 32;

endpackage : adder_pkg

// File: rtl/adder_full_adder_ha.sv
// 1-bit full adder from two half-adders plus an OR; purely combinational.
// No state and no flow control: output follows inputs within the cycle.
module full_adder_ha (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    logic ha0_sum;
    logic ha0_carry;
    logic ha1_carry;

    // First half-adder combines the operands, second folds in the carry.
    assign ha0_sum   = a ^ b;
    assign ha0_carry = a & b;
    assign sum       = ha0_sum ^ cin;
    assign ha1_carry = ha0_sum & cin;
    assign cout      = ha0_carry | ha1_carry;

endmodule : full_adder_ha

// File: rtl/adder.sv
// N-bit ripple-carry adder with a behavioural reference sum; 1-cycle registered latency.
// No back-pressure: a new operand set is accepted every cycle while in_valid is high.
module adder
    import adder_pkg::*;
#(
    parameter int N = ADDER_WIDTH
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic         out_valid,
    output logic [N-1:0] sum,
    output logic         cout,
    output logic [N:0]   result,
    output logic [N:0]   resultx
);

    logic [N:0]   carry;
    logic [N-1:0] sum_rc;
    logic [N:0]   resultx_c;

    logic [N-1:0] sum_d,       sum_q;
    logic         cout_d,      cout_q;
    logic [N:0]   resultx_d,   resultx_q;
    logic         out_valid_d, out_valid_q;

    assign carry[0] = cin;

    for (genvar i = 0; i < N; i++) begin : g_ripple
        full_adder_ha u_fa (
            .a   (a[i]),
            .b   (b[i]),
            .cin (carry[i]),
            .sum (sum_rc[i]),
            .cout(carry[i+1])
        );
    end

    // Zero-extend before adding so the reference carries into bit N instead of truncating.
    assign resultx_c = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};

    always_comb begin
        sum_d       = sum_q;
        cout_d      = cout_q;
        resultx_d   = resultx_q;
        out_valid_d = in_valid;
        if (in_valid) begin
            sum_d     = sum_rc;
            cout_d    = carry[N];
            resultx_d = resultx_c;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q       <= '0;
            cout_q      <= 1'b0;
            resultx_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            resultx_q   <= resultx_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign result    = {cout_q, sum_q};
    assign resultx   = resultx_q;

endmodule : adder

// File: tb/tb_adder.sv
// Directed and random stimulus for the adder, checked against a queued expected-result model.
module tb_adder;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         out_valid;
    logic [W-1:0] sum;
    logic         cout;
    logic [W:0]   result;
    logic [W:0]   resultx;

    logic [3:0]   a4 = '0;
    logic [3:0]   b4 = '0;
    logic         out_valid4;
    logic [3:0]   sum4;
    logic         cout4;
    logic [4:0]   result4;
    logic [4:0]   resultx4;

    always #5 clk = ~clk;

    adder #(.N(W)) u_dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .out_valid(out_valid),
        .sum      (sum),
        .cout     (cout),
        .result   (result),
        .resultx  (resultx)
    );

    adder #(.N(4)) u_dut4 (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .a        (a4),
        .b        (b4),
        .cin      (cin),
        .out_valid(out_valid4),
        .sum      (sum4),
        .cout     (cout4),
        .result   (result4),
        .resultx  (resultx4)
    );

    typedef struct packed {
        logic [W-1:0] s;
        logic         c;
        logic [W:0]   r;
    } exp_t;

    exp_t sb[$];
    exp_t last;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input logic exp_vld);
        chk({tag, "_out_valid"}, 64'(out_valid), 64'(exp_vld));
        chk({tag, "_sum"},       64'(sum),       64'(last.s));
        chk({tag, "_cout"},      64'(cout),      64'(last.c));
        chk({tag, "_result"},    64'(result),    64'(last.r));
        chk({tag, "_resultx"},   64'(resultx),   64'(last.r));
    endtask

    // Drive one cycle of inputs, advance one edge, then compare against the model.
    task automatic step(input string tag, input logic r, input logic v,
                        input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv);
        exp_t e;
        rst      = r;
        in_valid = v;
        a        = av;
        b        = bv;
        cin      = cv;
        if (!r && v) begin
            e.r = {1'b0, av} + {1'b0, bv} + {{W{1'b0}}, cv};
            e.s = e.r[W-1:0];
            e.c = e.r[W];
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        if (r) begin
            last = '0;
            check_outputs(tag, 1'b0);
        end else if (v) begin
            if (sb.size() == 0) begin
                chk({tag, "_sb_empty"}, 64'(sb.size()), 64'd1);
            end else begin
                last = sb.pop_front();
                check_outputs(tag, 1'b1);
            end
        end else begin
            check_outputs(tag, 1'b0);
        end
    endtask

    initial begin
        step("rst0", 1'b1, 1'b0, '0, '0, 1'b0);
        step("rst1", 1'b1, 1'b0, '0, '0, 1'b0);

        a4 = 4'hF;
        b4 = 4'h1;
        step("basic", 1'b0, 1'b1, 32'h1234_5678, 32'h1111_1111, 1'b0);
        chk("basic_sum_lit",  64'(sum),    64'h2345_6789);
        chk("basic_res_lit",  64'(result), 64'h0_2345_6789);
        chk("n4_out_valid",   64'(out_valid4), 64'd1);
        chk("n4_sum",         64'(sum4),       64'h0);
        chk("n4_cout",        64'(cout4),      64'd1);
        chk("n4_result",      64'(result4),    64'h10);
        chk("n4_resultx",     64'(resultx4),   64'h10);

        step("ones_zero_cin", 1'b0, 1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
        chk("ones_zero_res_lit", 64'(result), 64'h1_0000_0000);
        step("all_ones", 1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        chk("all_ones_res_lit", 64'(result), 64'h1_FFFF_FFFF);
        step("all_zero", 1'b0, 1'b1, 32'h0, 32'h0, 1'b0);
        chk("all_zero_res_lit", 64'(result), 64'h0);
        step("pre_hold", 1'b0, 1'b1, 32'h8000_0001, 32'h7FFF_FFFF, 1'b1);

        for (int i = 0; i < 3; i++) begin
            step("hold", 1'b0, 1'b0, $urandom, $urandom, 1'b1);
        end

        // Raising and dropping rst between edges must leave the registers untouched.
        rst = 1'b1;
        #3;
        chk("midcycle_rst_sum", 64'(sum), 64'(last.s));
        rst = 1'b0;

        step("rst_wins", 1'b1, 1'b1, 32'hDEAD_BEEF, 32'h1234_5678, 1'b1);
        chk("rst_wins_n4_valid",  64'(out_valid4), 64'd0);
        chk("rst_wins_n4_result", 64'(result4),    64'h0);
        chk("rst_wins_sb_empty",  64'(sb.size()),  64'd0);
        step("post_rst_idle", 1'b0, 1'b0, 32'h5, 32'h6, 1'b0);
        step("post_rst_first", 1'b0, 1'b1, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 1'b1);

        for (int i = 0; i < 1000; i++) begin
            step("rand", 1'b0, 1'b1, $urandom, $urandom, 1'($urandom_range(0, 1)));
        end

        step("final_idle", 1'b0, 1'b0, '0, '0, 1'b0);
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_adder

// File: doc/adder.md
ADDER -- requirements
Module: adder

Interface
REQ-001 Parameter N, default 32, meaning operand width in bits; SHALL be legal for any N >= 1.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  operands valid this cycle.
REQ-005 a  input  N  addend A, unsigned.
REQ-006 b  input  N  addend B, unsigned.
REQ-007 cin  input  1  carry-in.
REQ-008 out_valid  output  1  registered outputs hold a new result.
REQ-009 sum  output  N  low N bits of a+b+cin, from the ripple-carry chain.
REQ-010 cout  output  1  carry-out of the ripple-carry chain.
REQ-011 result  output  N+1  {cout,sum}, the ripple-carry result as one word.
REQ-012 resultx  output  N+1  a+b+cin computed by a behavioural N+1-bit add, used as a reference result.

Function
REQ-013 The ripple path SHALL be N cascaded 1-bit full adders; stage i takes a[i], b[i], carry[i] and produces sum bit i and carry[i+1]; carry[0]=cin; cout=carry[N].
REQ-014 resultx SHALL zero-extend a and b to N+1 bits before adding cin, so it never truncates.
REQ-015 All arithmetic SHALL be unsigned and modulo 2^(N+1); no overflow flag beyond cout.
REQ-016 Latency SHALL be exactly 1 cycle: operands sampled at edge k appear on sum/cout/result/resultx after edge k.
REQ-017 When in_valid=1 at an edge, all four data outputs SHALL be updated and out_valid SHALL be 1 after that edge.
REQ-018 When in_valid=0 at an edge, the data outputs SHALL hold their previous values and out_valid SHALL be 0.
REQ-019 result SHALL equal resultx for every input combination; any difference is a design error.
REQ-020 Boundary: a=b=all-ones, cin=1 SHALL give sum=all-ones, cout=1; a=b=0, cin=0 SHALL give all zeros.
REQ-021 No back-pressure; a new operand set is accepted every cycle (throughput 1/cycle).

Reset
REQ-022 While rst=1 at a rising edge: sum, cout, result, resultx SHALL be 0 and out_valid SHALL be 0 after that edge.
REQ-023 rst SHALL take priority over in_valid on the same edge; an operand presented with rst=1 SHALL be discarded.
REQ-024 The first valid result after rst is released SHALL appear one cycle after the first in_valid=1 edge.
REQ-025 Reset SHALL have no effect between clock edges (synchronous only).

Structure
REQ-026 A shared package SHALL hold the default width constant (32) and nothing else is required.
REQ-027 One sub-module, full_adder_ha: 1-bit full adder built from two half-adders (XOR/AND) plus an OR for carry; ports a, b, cin, sum, cout.
REQ-028 The top SHALL instantiate N copies of full_adder_ha with a generate loop; the behavioural resultx path and the output register stage SHALL be in the top.
REQ-029 The combinational path SHALL have no latches; only the output registers and out_valid are state.

Verification
REQ-030 rst=1 for 2 cycles, then a=0x12345678, b=0x11111111, cin=0, in_valid=1 -> next cycle sum=0x23456789, cout=0, result=resultx=0x0_23456789, out_valid=1.
REQ-031 a=0xFFFFFFFF, b=0x00000000, cin=1 -> sum=0x00000000, cout=1, result=resultx=0x1_00000000.
REQ-032 a=0xFFFFFFFF, b=0xFFFFFFFF, cin=1 -> sum=0xFFFFFFFF, cout=1, result=resultx=0x1_FFFFFFFF.
REQ-033 in_valid=0 for 3 cycles after a valid op -> outputs held, out_valid=0; asserting rst=1 together with in_valid=1 -> all outputs 0 next cycle.
REQ-034 1000 random a, b, cin with in_valid=1 every cycle -> each cycle result==resultx=={cout,sum}==a+b+cin of the prior cycle.
REQ-035 N=4 instance: a=0xF, b=0x1, cin=0 -> sum=0x0, cout=1, result=0x10.
